icache_refill_ctrl: RTL

Miss/refill sequencer for the instruction cache in the 5-stage RISC-V fetch stage. On each fetch it checks the cache array. On a miss it stalls IF, fetches a 4-word line from backing memory over a req/gnt + rvalid bus, and writes the line into the array. It then returns the requested word. It also sequences whole-cache invalidation.

---
 rtl/icache_pkg.sv | 45 ++++
 rtl/icache_line_buf.sv | 35 +++
 rtl/icache_refill_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: geometry, FSM state type and address/line helpers shared by the
// instruction-cache refill controller and its line buffer.
package icache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = 32 - INDEX_W - 4;
  localparam int LINE_W     = 32 * LINE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FILL  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4,
    S_INV   = 3'd5
  } state_e;

  function automatic logic [1:0] addr_offset(input logic [31:0] addr);
    return addr[3:2];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[4+INDEX_W-1:4];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:4+INDEX_W];
  endfunction

  // Word 0 of a line lives in the most significant 32 bits.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        w);
    logic [31:0] word;
    case (w)
      2'd0:    word = line[127:96];
      2'd1:    word = line[95:64];
      2'd2:    word = line[63:32];
      2'd3:    word = line[31:0];
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// icache_line_buf: collects the four refill beats of a cache line in arrival
// order; clear restarts assembly at word 0.
module icache_line_buf
  import icache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [31:0]       i_data,
  output logic [1:0]        o_beat,
  output logic [LINE_W-1:0] o_line
);

  logic [31:0] r_word [LINE_WORDS];
  logic [1:0]  r_beat;

  // Store each accepted beat at the current word slot and advance the 2-bit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat <= 2'd0;
      for (int i = 0; i < LINE_WORDS; i++) r_word[i] <= 32'h0000_0000;
    end else if (i_clr) begin
      r_beat <= 2'd0;
      for (int i = 0; i < LINE_WORDS; i++) r_word[i] <= 32'h0000_0000;
    end else if (i_load) begin
      r_word[r_beat] <= i_data;
      r_beat         <= r_beat + 2'd1;
    end
  end

  assign o_beat = r_beat;
  assign o_line = {r_word[0], r_word[1], r_word[2], r_word[3]};

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: hit/miss sequencer for the fetch-stage instruction cache.
// Hits answer in the lookup cycle; misses fetch a 4-word line over req/gnt +
// rvalid, write it to the array and return the requested word. fence.i
// flushes are serviced from IDLE, deferred with a sticky flag otherwise.
// Optional feature macro: ICACHE_PERF_CNT_EN (hit/miss saturating counters).
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [31:0]        cpu_addr,
  output logic               cpu_ready,
  output logic [31:0]        cpu_data,
  output logic               stall,
  input  logic               flush,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt,
`endif
  output logic [INDEX_W-1:0] cache_index,
  output logic [TAG_W-1:0]   cache_tag,
  input  logic               cache_hit,
  input  logic [LINE_W-1:0]  cache_rline,
  output logic               cache_we,
  output logic [LINE_W-1:0]  cache_wline,
  output logic               cache_inv_all,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata
);

  state_e              r_state;
  state_e              w_next;
  logic [31:0]         r_addr;
  logic                r_flush_pend;
  logic                w_latch;
  logic                w_buf_clr;
  logic                w_buf_load;
  logic                w_hit_evt;
  logic [1:0]          w_beat;
  logic [LINE_W-1:0]   w_line;

  icache_line_buf u_line_buf (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_buf_clr),
    .i_load  (w_buf_load),
    .i_data  (mem_rdata),
    .o_beat  (w_beat),
    .o_line  (w_line)
  );

  // State register; reset abandons any refill in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Miss address is captured when leaving IDLE and drives the array afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_addr <= 32'h0000_0000;
    else if (w_latch) r_addr <= cpu_addr;
  end

  // Flush seen while busy is remembered and serviced on the next IDLE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_flush_pend <= 1'b0;
    else if (r_state == S_IDLE)                r_flush_pend <= 1'b0;
    else if (flush && (r_state != S_INV))      r_flush_pend <= 1'b1;
  end

  // Next-state and output decode; reset masks the combinational hit response.
  always_comb begin
    w_next        = r_state;
    cpu_ready     = 1'b0;
    cpu_data      = 32'h0000_0000;
    mem_req       = 1'b0;
    mem_addr      = 32'h0000_0000;
    cache_we      = 1'b0;
    cache_wline   = {LINE_W{1'b0}};
    cache_inv_all = 1'b0;
    w_latch       = 1'b0;
    w_buf_clr     = 1'b0;
    w_buf_load    = 1'b0;
    w_hit_evt     = 1'b0;
    cache_index   = addr_index(r_addr);
    cache_tag     = addr_tag(r_addr);
    case (r_state)
      S_IDLE: begin
        cache_index = addr_index(cpu_addr);
        cache_tag   = addr_tag(cpu_addr);
        if (flush || r_flush_pend) begin
          w_next = S_INV;
        end else if (cpu_req && cache_hit && rst) begin
          cpu_ready = 1'b1;
          cpu_data  = line_word(cache_rline, addr_offset(cpu_addr));
          w_hit_evt = 1'b1;
          w_next    = S_IDLE;
        end else if (cpu_req) begin
          w_latch   = 1'b1;
          w_buf_clr = 1'b1;
          w_next    = S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[31:4], 4'h0};
        if (mem_gnt) begin
          w_buf_load = mem_rvalid;
          w_next     = S_FILL;
        end else begin
          w_next = S_REQ;
        end
      end
      S_FILL: begin
        w_buf_load = mem_rvalid;
        if (mem_rvalid && (w_beat == 2'd3)) w_next = S_WRITE;
        else                                w_next = S_FILL;
      end
      S_WRITE: begin
        cache_we    = 1'b1;
        cache_wline = w_line;
        w_next      = S_RESP;
      end
      S_RESP: begin
        cpu_ready = 1'b1;
        cpu_data  = line_word(w_line, addr_offset(r_addr));
        w_next    = S_IDLE;
      end
      S_INV: begin
        cache_inv_all = 1'b1;
        w_next        = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign stall = cpu_req & ~cpu_ready;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating hit/miss counters, restarted by every invalidate-all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= 32'h0000_0000;
      r_miss_cnt <= 32'h0000_0000;
    end else if (cache_inv_all) begin
      r_hit_cnt  <= 32'h0000_0000;
      r_miss_cnt <= 32'h0000_0000;
    end else begin
      if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF))  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_latch && (r_miss_cnt != 32'hFFFF_FFFF))   r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
